// File: rtl/starter_loader.sv
// starter_loader: operator-start sequencer and initial-orders loader.
// Deserialises serial orders LSB first and writes them to the store.
module starter_loader #(
    parameter int WORD_WIDTH = 17,
    parameter int NUM_WORDS  = 31,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  io_bit,
    input  logic                  io_bit_valid,
    input  logic                  wr_ready,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  starter,
    output logic                  starter_neg,
    output logic                  reset_cntr_neg,
    output logic                  reset_sct_neg,
    output logic                  boot_valid,
    output logic                  overrun
);

    localparam int BCW = $clog2(WORD_WIDTH);
    localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_WIDTH - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        WRITE,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  start_q;
    logic                  start_rise;
    logic [BCW-1:0]        bit_cnt;
    logic [WCW-1:0]        word_cnt;
    // Holds the bits received so far; the incoming bit completes a word.
    logic [WORD_WIDTH-2:0] shreg;
    logic [WORD_WIDTH-1:0] word_nx;
    logic                  last_bit;

    assign start_rise = start & ~start_q;
    assign word_nx    = {io_bit, shreg};
    assign last_bit   = io_bit_valid && (bit_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and outputs decoded from the registered state.
    always_comb begin
        state_d        = state_q;
        wr_valid       = 1'b0;
        starter        = 1'b0;
        reset_cntr_neg = 1'b1;
        reset_sct_neg  = 1'b1;
        boot_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) state_d = CLEAR;
            end
            CLEAR: begin
                starter        = 1'b1;
                reset_cntr_neg = 1'b0;
                reset_sct_neg  = 1'b0;
                state_d        = SHIFT;
            end
            SHIFT: begin
                starter = 1'b1;
                if (last_bit) state_d = WRITE;
            end
            WRITE: begin
                starter  = 1'b1;
                wr_valid = 1'b1;
                if (wr_ready) begin
                    state_d = (word_cnt == LAST_WORD) ? DONE : SHIFT;
                end
            end
            DONE: begin
                boot_valid = 1'b1;
                if (start_rise) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
        starter_neg = ~starter;
    end

    // Start edge detector, deserialiser, counters and write port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            overrun  <= 1'b0;
        end else begin
            start_q <= start;
            case (state_q)
                CLEAR: begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    shreg    <= '0;
                    overrun  <= 1'b0;
                end
                SHIFT: begin
                    if (io_bit_valid) begin
                        shreg <= word_nx[WORD_WIDTH-1:1];
                        if (last_bit) begin
                            bit_cnt <= '0;
                            wr_data <= word_nx;
                            wr_addr <= BASE + ADDR_WIDTH'(word_cnt);
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // The serial line cannot be stalled, so a bit here is lost.
                    if (io_bit_valid) overrun <= 1'b1;
                    if (wr_ready && (word_cnt != LAST_WORD)) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_starter_loader.sv
// tb_starter_loader: randomized and directed checks of starter_loader
// against a transaction-level reference model.
module tb_starter_loader;

    localparam int WW = 8;
    localparam int NW = 5;
    localparam int AW = 10;
    localparam int BA = 1022;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_LOAD  = 2;
    localparam int P_WRITE = 3;
    localparam int P_DONE  = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          io_bit;
    logic          io_bit_valid;
    logic          wr_ready;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          starter;
    logic          starter_neg;
    logic          reset_cntr_neg;
    logic          reset_sct_neg;
    logic          boot_valid;
    logic          overrun;

    starter_loader #(
        .WORD_WIDTH(WW),
        .NUM_WORDS (NW),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BA)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .io_bit        (io_bit),
        .io_bit_valid  (io_bit_valid),
        .wr_ready      (wr_ready),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .starter       (starter),
        .starter_neg   (starter_neg),
        .reset_cntr_neg(reset_cntr_neg),
        .reset_sct_neg (reset_sct_neg),
        .boot_valid    (boot_valid),
        .overrun       (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase, bits gathered, word index.
    int            m_ph   = P_IDLE;
    int            m_nb   = 0;
    int            m_idx  = 0;
    logic [WW-1:0] m_word = '0;
    logic [WW-1:0] m_data = '0;
    logic [AW-1:0] m_addr = '0;
    logic          m_ov   = 1'b0;
    logic          m_sq   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= P_IDLE;
            m_nb   <= 0;
            m_idx  <= 0;
            m_word <= '0;
            m_data <= '0;
            m_addr <= '0;
            m_ov   <= 1'b0;
            m_sq   <= 1'b0;
        end else begin
            m_sq <= start;
            case (m_ph)
                P_IDLE, P_DONE: begin
                    if (start && !m_sq) m_ph <= P_CLEAR;
                end
                P_CLEAR: begin
                    m_nb   <= 0;
                    m_idx  <= 0;
                    m_word <= '0;
                    m_ov   <= 1'b0;
                    m_ph   <= P_LOAD;
                end
                P_LOAD: begin
                    if (io_bit_valid) begin
                        if (m_nb == WW - 1) begin
                            m_data <= m_word | (WW'(io_bit) << (WW - 1));
                            m_addr <= AW'((BA + m_idx) % (1 << AW));
                            m_nb   <= 0;
                            m_word <= '0;
                            m_ph   <= P_WRITE;
                        end else begin
                            m_word[m_nb] <= io_bit;
                            m_nb         <= m_nb + 1;
                        end
                    end
                end
                P_WRITE: begin
                    if (io_bit_valid) m_ov <= 1'b1;
                    if (wr_ready) begin
                        if (m_idx == NW - 1) begin
                            m_ph <= P_DONE;
                        end else begin
                            m_idx <= m_idx + 1;
                            m_ph  <= P_LOAD;
                        end
                    end
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    int             vecs      = 0;
    int             bad       = 0;
    int             cyc       = 0;
    int             hs        = 0;
    int             stalls    = 0;
    int             clears    = 0;
    int             clear_cyc = 0;
    int             boot_cyc  = 0;
    logic           prev_boot = 1'b0;
    logic [AW+WW-1:0] wlog[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // One cycle: compare against the model mid-cycle, then advance.
    task automatic tick();
        @(negedge clk);
        chk("wr_valid", 32'(wr_valid), 32'(m_ph == P_WRITE));
        chk("starter", 32'(starter),
            32'(m_ph == P_CLEAR || m_ph == P_LOAD || m_ph == P_WRITE));
        chk("starter_neg", 32'(starter_neg),
            32'(!(m_ph == P_CLEAR || m_ph == P_LOAD || m_ph == P_WRITE)));
        chk("reset_cntr_neg", 32'(reset_cntr_neg), 32'(m_ph != P_CLEAR));
        chk("reset_sct_neg", 32'(reset_sct_neg), 32'(m_ph != P_CLEAR));
        chk("boot_valid", 32'(boot_valid), 32'(m_ph == P_DONE));
        chk("overrun", 32'(overrun), 32'(m_ov));
        if (m_ph == P_WRITE) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("wr_data", 32'(wr_data), 32'(m_data));
        end
        if (wr_valid && wr_ready) begin
            hs++;
            wlog.push_back({wr_addr, wr_data});
        end
        if (wr_valid && !wr_ready) stalls++;
        if (!reset_cntr_neg) begin
            clears++;
            clear_cyc = cyc;
        end
        if (boot_valid && !prev_boot) boot_cyc = cyc;
        prev_boot = boot_valid;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic do_start(bit hold);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        io_bit_valid = 1'b1;
        io_bit       = 1'b1;
        tick();
        io_bit_valid = 1'b0;
    endtask

    task automatic send_word(logic [WW-1:0] w, bit stall, bit ov);
        int n;
        wr_ready = 1'b1;
        for (int i = 0; i < WW; i++) begin
            io_bit_valid = 1'b1;
            io_bit       = w[i];
            tick();
        end
        io_bit_valid = 1'b0;
        if (stall) begin
            wr_ready = 1'b0;
            for (int j = 0; j < 5; j++) begin
                io_bit_valid = ov && (j == 1);
                io_bit       = 1'b1;
                tick();
            end
            io_bit_valid = 1'b0;
            wr_ready     = 1'b1;
        end
        n = 0;
        while (wr_valid && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("write_timeout", 32'(wr_valid), 32'(0));
    endtask

    task automatic run_load(logic [WW-1:0] w[NW], int stall_w, bit ov);
        for (int k = 0; k < NW; k++) send_word(w[k], k == stall_w, ov);
    endtask

    logic [WW-1:0] wa[NW];
    logic [WW-1:0] wb[NW];
    int            c0;
    int            h0;
    int            s0;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        io_bit       = 1'b0;
        io_bit_valid = 1'b0;
        wr_ready     = 1'b1;
        wa = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h5A};
        #2;
        tick();
        tick();
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'(0));
        chk("rst_starter_neg", 32'(starter_neg), 32'(1));
        chk("rst_cntr_neg", 32'(reset_cntr_neg), 32'(1));
        chk("rst_boot", 32'(boot_valid), 32'(0));
        rst_n = 1'b1;
        tick();
        tick();

        // Known words, full speed, address wrap past the top of store.
        wlog.delete();
        h0 = hs;
        do_start(1'b0);
        run_load(wa, -1, 1'b0);
        tick();
        chk("A_boot", 32'(boot_valid), 32'(1));
        chk("A_load_time", 32'(boot_cyc - clear_cyc), 32'(46));
        chk("A_writes", 32'(hs - h0), 32'(5));
        chk("A_w0", 32'(wlog[0]), 32'({10'd1022, 8'hA5}));
        chk("A_w1", 32'(wlog[1]), 32'({10'd1023, 8'h3C}));
        chk("A_w2", 32'(wlog[2]), 32'({10'd0, 8'h00}));
        chk("A_w4", 32'(wlog[4]), 32'({10'd2, 8'h5A}));
        chk("A_overrun", 32'(overrun), 32'(0));

        // Back-pressure on word 3, no bits during the stall.
        for (int k = 0; k < NW; k++) wb[k] = WW'($urandom);
        wlog.delete();
        h0 = hs;
        s0 = stalls;
        do_start(1'b0);
        run_load(wb, 3, 1'b0);
        tick();
        chk("B_stalls", 32'(stalls - s0), 32'(5));
        chk("B_writes", 32'(hs - h0), 32'(5));
        chk("B_w3", 32'(wlog[3]), 32'({10'd1, wb[3]}));
        chk("B_overrun", 32'(overrun), 32'(0));

        // One bit lost during a stalled write on word 2.
        for (int k = 0; k < NW; k++) wb[k] = WW'($urandom);
        wlog.delete();
        do_start(1'b0);
        run_load(wb, 2, 1'b1);
        tick();
        chk("C_overrun", 32'(overrun), 32'(1));
        chk("C_boot", 32'(boot_valid), 32'(1));
        chk("C_w3", 32'(wlog[3][WW-1:0]), 32'(wb[3]));
        do_start(1'b0);
        chk("C_overrun_clr", 32'(overrun), 32'(0));
        run_load(wa, -1, 1'b0);
        tick();

        // Held start, ignored mid-load pulse, restart after done.
        c0 = clears;
        do_start(1'b1);
        send_word(wa[0], 1'b0, 1'b0);
        send_word(wa[1], 1'b0, 1'b0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 2; k < NW; k++) send_word(wa[k], 1'b0, 1'b0);
        tick();
        chk("D_clears1", 32'(clears - c0), 32'(1));
        chk("D_boot", 32'(boot_valid), 32'(1));
        wlog.delete();
        do_start(1'b0);
        chk("D_clears2", 32'(clears - c0), 32'(2));
        run_load(wa, -1, 1'b0);
        tick();
        chk("D_restart_w0", 32'(wlog[0]), 32'({10'd1022, 8'hA5}));

        // Asynchronous reset part-way through the last word.
        do_start(1'b0);
        for (int k = 0; k < NW - 1; k++) send_word(wa[k], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            io_bit_valid = 1'b1;
            io_bit       = wa[4][i];
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("E_wr_valid", 32'(wr_valid), 32'(0));
        chk("E_starter", 32'(starter), 32'(0));
        chk("E_starter_neg", 32'(starter_neg), 32'(1));
        chk("E_sct_neg", 32'(reset_sct_neg), 32'(1));
        chk("E_boot", 32'(boot_valid), 32'(0));
        chk("E_wr_addr", 32'(wr_addr), 32'(0));
        chk("E_wr_data", 32'(wr_data), 32'(0));
        h0 = hs;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            io_bit_valid = 1'b1;
            io_bit       = 1'($urandom);
            tick();
        end
        io_bit_valid = 1'b0;
        chk("E_no_writes", 32'(hs - h0), 32'(0));
        chk("E_idle_boot", 32'(boot_valid), 32'(0));

        // Random traffic, starts, stalls and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            io_bit_valid = ($urandom % 4) != 0;
            io_bit       = 1'($urandom);
            wr_ready     = ($urandom % 3) != 0;
            if ($urandom % 40 == 0) start = ~start;
            rst_n = ($urandom % 600) != 0;
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule

// File: doc/starter_loader.md
# starter_loader

Parametrised starter unit and initial-orders loader for the EDSAC core. On an operator start it clears the control counters, then deserialises a configurable number of initial-order words from the serial initial-orders line. Each word is written into the store through a valid/ready write port starting at a configurable base address. When the last word has been accepted it releases the machine via `boot_valid`. It generalises the fixed starter in word width, order count and load address, and adds write back-pressure, an overrun flag and a completion handshake.

## Interface
- `WORD_WIDTH`, 17: bits per initial order, serial LSB first; must be ≥ 2.
- `NUM_WORDS`, 31: number of orders loaded per start; must be ≥ 1.
- `ADDR_WIDTH`, 10: store address width.
- `BASE_ADDR`, 0: store address of the first order.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  operator start level; only its rising edge acts.
- `io_bit`  in  1  serial initial-orders data.
- `io_bit_valid`  in  1  `io_bit` is a new bit this cycle (minor-cycle strobe).
- `wr_ready`  in  1  store accepts the write this cycle.
- `wr_valid`  out  1  write request.
- `wr_addr`  out  ADDR_WIDTH  write address.
- `wr_data`  out  WORD_WIDTH  assembled order.
- `starter`  out  1  high while a load is in progress (CLEAR, SHIFT, WRITE).
- `starter_neg`  out  1  `~starter`.
- `reset_cntr_neg`  out  1  active-low, one-cycle clear of the order counter.
- `reset_sct_neg`  out  1  active-low, one-cycle clear of the sequence control tank.
- `boot_valid`  out  1  load complete; level, held until the next start.
- `overrun`  out  1  sticky; a serial bit arrived while a write was pending.

## Operation
- States: IDLE, CLEAR, SHIFT, WRITE, DONE.
- Start detect: `start` is registered each cycle. `start_rise` = `start & ~start_q`.
- IDLE → CLEAR on `start_rise`.
- DONE → CLEAR on `start_rise`.
- `start_rise` in CLEAR, SHIFT or WRITE is ignored.
- CLEAR (one cycle):
  - `reset_cntr_neg` = `reset_sct_neg` = 0.
  - `bit_cnt`, `word_cnt`, shift register, `overrun` and `boot_valid` cleared.
  - Next state SHIFT.
- SHIFT:
  - When `io_bit_valid`: `shreg <= {io_bit, shreg[WORD_WIDTH-1:1]}` and `bit_cnt++`.
  - When `io_bit_valid` and `bit_cnt == WORD_WIDTH-1`: `wr_data` is loaded with the completed word, `bit_cnt` ← 0, next state WRITE.
- WRITE:
  - `wr_valid` = 1, `wr_addr` = `BASE_ADDR + word_cnt` (mod 2^ADDR_WIDTH).
  - `wr_addr` and `wr_data` are held stable until `wr_valid & wr_ready`.
  - Any `io_bit_valid` in WRITE is discarded and sets `overrun`.
  - On handshake: if `word_cnt == NUM_WORDS-1` → DONE, else `word_cnt++` → SHIFT.
- DONE: `boot_valid` = 1, `starter` = 0. The state is held until the next `start_rise`.
- `word_cnt` width is clog2(NUM_WORDS), minimum 1. `bit_cnt` width is clog2(WORD_WIDTH).
- Reset mid-operation: everything returns to IDLE immediately. The partial word is lost, no write is issued, and `boot_valid` stays 0.

## Timing
- Reset values:
  - state IDLE
  - `wr_valid` 0, `wr_addr` 0, `wr_data` 0
  - `starter` 0, `starter_neg` 1
  - `reset_cntr_neg` 1, `reset_sct_neg` 1
  - `boot_valid` 0, `overrun` 0
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- `start_rise` detected at edge N: CLEAR is active in cycle N+1, with the clear pulses low for exactly that cycle. SHIFT begins at N+2.
- Bits with `io_bit_valid` in the CLEAR cycle are ignored.
- The last bit of a word is sampled at edge M; `wr_valid` is high from cycle M+1.
- A handshake at edge K drops `wr_valid` in cycle K+1.
  - If that was the final word, `boot_valid` rises in K+1.
  - Otherwise SHIFT resumes in K+1 and a bit valid in K+1 is captured.
- Minimum load time with `wr_ready` tied high and a bit every cycle: 1 + NUM_WORDS × (WORD_WIDTH + 1) cycles from CLEAR to DONE.

## Test plan
- Default parameters, `wr_ready` = 1, a bit every cycle, words 0..30 = address index: 31 writes at addresses 0..30 with `wr_data` = index. `boot_valid` rises 1 + 31×18 = 559 cycles after CLEAR. `overrun` = 0.
- `WORD_WIDTH` = 8, `NUM_WORDS` = 2, `BASE_ADDR` = 1022, `ADDR_WIDTH` = 10, serial 0xA5 then 0x3C (LSB first): writes (1022, 0xA5) and (1023, 0x3C), then `boot_valid` = 1.
- Back-pressure: `wr_ready` low for 5 cycles on word 3, no bits sent during that time: `wr_valid`, `wr_addr` and `wr_data` are stable for all 6 cycles and exactly one write occurs.
- Overrun: one `io_bit_valid` during a stalled WRITE: `overrun` = 1 and stays 1 until the next CLEAR. The next word is assembled from subsequent bits only.
- `start` held high for 100 cycles, pulsed again mid-load, then pulsed after DONE: only the first and last pulses produce a single-cycle `reset_cntr_neg`/`reset_sct_neg` low, and the load restarts at `BASE_ADDR`.
- `rst_n` asserted while 9 bits into word 4: all outputs return to their reset values asynchronously, and no further writes occur until a new start.
